// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the clock period meter and the dividers it checks.
// A divider with toggle constant k produces a half-period of k+1 system cycles.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } meas_state_e;

    localparam int unsigned DEF_WIDTH    = 32'd26;
    localparam int unsigned DEF_TIMEOUT  = 32'd50000000;
    localparam int unsigned DEF_MIN_HALF = 32'd2;
    localparam int unsigned DEF_DIV_K    = 32'd4;

    function automatic int unsigned half_period_for_k(input int unsigned k);
        return k + 32'd1;
    endfunction

endpackage

// File: rtl/clk_period_meter_sync.sv
// Two-flop synchroniser plus a delay flop; edge_o flags either polarity of the
// synchronised input for one cycle.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain and one-cycle delay for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures half-period and full period of a toggling input in system clock cycles,
// rejecting glitches shorter than MIN_HALF and flagging a dead signal after TIMEOUT.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned MIN_HALF = DEF_MIN_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] half_period,
    output logic [WIDTH:0]   period,
    output logic             meas_valid,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_MAX_W = WIDTH'(TIMEOUT - 32'd1);
    localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_HALF);

    meas_state_e      state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] prev_half_q;
    logic             have_prev_q;
    logic [WIDTH-1:0] half_period_q;
    logic [WIDTH:0]   period_q;
    logic             meas_valid_q;
    logic             period_valid_q;
    logic             timeout_q;

    logic             edge_s;
    logic [WIDTH-1:0] m_s;
    logic             accept_s;
    logic             dead_s;

    sync_edge_det u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .sig_i  (sig_in),
        .edge_o (edge_s)
    );

    // cnt never exceeds TIMEOUT-1, so m fits in WIDTH bits.
    assign m_s      = cnt_q + ONE_W;
    assign accept_s = edge_s && (m_s >= MIN_W);
    assign dead_s   = !accept_s && (m_s == TIMEOUT_W);

    // Measurement state machine with registered data and valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= ZERO_W;
            prev_half_q    <= ZERO_W;
            have_prev_q    <= 1'b0;
            half_period_q  <= ZERO_W;
            period_q       <= {(WIDTH+1){1'b0}};
            meas_valid_q   <= 1'b0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            meas_valid_q   <= 1'b0;
            period_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (edge_s) begin
                        cnt_q   <= ZERO_W;
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (accept_s) begin
                        half_period_q <= m_s;
                        meas_valid_q  <= 1'b1;
                        cnt_q         <= ZERO_W;
                        if (have_prev_q) begin
                            period_q       <= {1'b0, prev_half_q} + {1'b0, m_s};
                            period_valid_q <= 1'b1;
                        end
                        prev_half_q <= m_s;
                        have_prev_q <= 1'b1;
                    end else if (dead_s) begin
                        state_q     <= ST_TIMEOUT;
                        timeout_q   <= 1'b1;
                        have_prev_q <= 1'b0;
                        cnt_q       <= ZERO_W;
                    end else if (cnt_q != CNT_MAX_W) begin
                        cnt_q <= cnt_q + ONE_W;
                    end
                end
                ST_TIMEOUT: begin
                    // The first edge after a dead period only re-arms the counter.
                    if (edge_s) begin
                        timeout_q <= 1'b0;
                        cnt_q     <= ZERO_W;
                        state_q   <= ST_MEASURE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= ZERO_W;
                    have_prev_q <= 1'b0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign half_period  = half_period_q;
    assign period       = period_q;
    assign meas_valid   = meas_valid_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter with WIDTH=8, TIMEOUT=100, MIN_HALF=3.
module tb_clk_period_meter;
    import clk_meas_pkg::*;

    localparam int unsigned DIV_K = DEF_DIV_K;

    logic       clk;
    logic       rst;
    logic       sig_man;
    logic       use_div;
    logic       div_run;
    logic       div_out;
    logic [7:0] div_cnt;
    logic       sig_in;
    logic [7:0] half_period;
    logic [8:0] period;
    logic       meas_valid;
    logic       period_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] half_exp_q[$];
    logic [8:0] per_exp_q[$];

    clk_period_meter #(
        .WIDTH    (8),
        .TIMEOUT  (100),
        .MIN_HALF (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .half_period  (half_period),
        .period       (period),
        .meas_valid   (meas_valid),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    assign sig_in = use_div ? div_out : sig_man;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference divider with toggle constant DIV_K, frozen while div_run is low.
    always_ff @(negedge clk) begin
        if (rst) begin
            div_cnt <= 8'd0;
            div_out <= 1'b0;
        end else if (div_run) begin
            if (div_cnt == 8'(DIV_K)) begin
                div_cnt <= 8'd0;
                div_out <= ~div_out;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tog(input int n);
        repeat (n) @(negedge clk);
        sig_man = ~sig_man;
    endtask

    task automatic exp_h(input int h);
        half_exp_q.push_back(8'(h));
    endtask

    task automatic exp_p(input int p);
        per_exp_q.push_back(9'(p));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_half"}, int'(half_period), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_period_valid"}, int'(period_valid), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Monitor: pops and compares an expectation for every valid pulse.
    initial begin
        logic meas_prev;
        logic per_prev;
        meas_prev = 1'b0;
        per_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (meas_valid) begin
                    check("meas_valid_gap", int'(meas_prev), 0);
                    if (half_exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL meas_unexpected: got half_period=%0d expected no pulse", half_period);
                    end else begin
                        check("half_period", int'(half_period), int'(half_exp_q.pop_front()));
                    end
                end
                if (period_valid) begin
                    check("period_valid_gap", int'(per_prev), 0);
                    if (per_exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL period_unexpected: got period=%0d expected no pulse", period);
                    end else begin
                        check("period", int'(period), int'(per_exp_q.pop_front()));
                    end
                end
            end
            meas_prev = meas_valid;
            per_prev  = period_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        sig_man = 1'b0;
        use_div = 1'b0;
        div_run = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Symmetric wave, toggle every 5.
        tog(5);
        tog(5); exp_h(5);
        for (int i = 0; i < 4; i++) begin
            tog(5); exp_h(5); exp_p(10);
        end

        // Asymmetric wave 7/3.
        tog(7); exp_h(7); exp_p(12);
        tog(3); exp_h(3); exp_p(10);
        tog(7); exp_h(7); exp_p(10);
        tog(3); exp_h(3); exp_p(10);
        tog(7); exp_h(7); exp_p(10);
        tog(3); exp_h(3); exp_p(10);

        // Glitch: 1-cycle pulse 10 cycles into a 20-cycle half.
        tog(20); exp_h(20); exp_p(23);
        tog(10); exp_h(10); exp_p(30);
        tog(1);
        tog(9);  exp_h(10); exp_p(20);
        tog(20); exp_h(20); exp_p(30);

        // Timeout exactly 100 cycles after the last accepted edge.
        repeat (102) @(negedge clk);
        check("timeout_early", int'(timeout), 0);
        repeat (1) @(negedge clk);
        check("timeout_set", int'(timeout), 1);
        check("timeout_hold_half", int'(half_period), 20);
        check("timeout_hold_period", int'(period), 30);
        repeat (20) @(negedge clk);
        check("timeout_stays", int'(timeout), 1);

        // Resume: first edge re-arms only.
        tog(5);
        repeat (4) @(negedge clk);
        check("timeout_cleared", int'(timeout), 0);
        tog(1); exp_h(5);
        tog(5); exp_h(5); exp_p(10);

        // Edge exactly at m = TIMEOUT wins over the timeout.
        tog(100); exp_h(100); exp_p(105);
        repeat (5) @(negedge clk);
        check("boundary_no_timeout", int'(timeout), 0);
        tog(0); exp_h(5); exp_p(105);

        // Asynchronous reset mid-count.
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        #4 rst = 1'b0;
        tog(5);
        tog(5); exp_h(5);
        tog(5); exp_h(5); exp_p(10);
        tog(5); exp_h(5); exp_p(10);

        // Divider-driven input after letting the meter go dead.
        repeat (110) @(negedge clk);
        check("pre_divider_timeout", int'(timeout), 1);
        @(posedge clk);
        use_div = 1'b1;
        div_run = 1'b1;
        for (int i = 0; i < 7; i++) exp_h(int'(half_period_for_k(DIV_K)));
        for (int i = 0; i < 6; i++) exp_p(10);
        repeat (42) @(negedge clk);
        @(posedge clk);
        div_run = 1'b0;
        repeat (10) @(negedge clk);

        check("half_queue_drained", half_exp_q.size(), 0);
        check("period_queue_drained", per_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures the half-period and full period of an incoming square wave, counted in cycles of the system clock.
- Intended source: the output of our clock dividers, or any toggling sensor/tone signal in the theremin path.
- It is the inverse of a divider: a divider with toggle constant k yields half_period = k+1.
- Outputs feed tone and pitch logic and self-check hooks.

Parameters:
- WIDTH, 26, width of the cycle counter and half_period output.
- TIMEOUT, 26'd50000000, cycles without an accepted edge before declaring the signal dead; must be less than 2^WIDTH.
- MIN_HALF, 26'd2, minimum accepted half-period in cycles; edges arriving sooner are rejected as glitches.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- sig_in, input, 1, asynchronous square wave to measure.
- half_period, output, WIDTH, cycles between the last two accepted edges.
- period, output, WIDTH+1, sum of the last two accepted half-periods (one high plus one low).
- meas_valid, output, 1, one-cycle pulse when half_period updates.
- period_valid, output, 1, one-cycle pulse when period updates.
- timeout, output, 1, high while the signal is considered dead.

Behaviour:
- Reset: async, active-high. All registers clear. Outputs: half_period=0, period=0, meas_valid=0, period_valid=0, timeout=0. State=IDLE, cnt=0, have_prev=0.
- Synchroniser: sig_in passes through 2 flops (s1, s2), then a third flop s3. edge = s2 ^ s3 (both polarities). Fixed 3-cycle input latency; it cancels out in the differences.
- cnt: increments every non-accepted-edge cycle in MEASURE. Saturates at TIMEOUT-1 and never wraps. Measured value m = cnt+1 = clock cycles between two accepted edge cycles.
- IDLE:
  - Wait for the first edge.
  - On edge: cnt<=0, go to MEASURE. No valid pulse.
- MEASURE, edge with m >= MIN_HALF:
  - half_period<=m, meas_valid<=1 for 1 cycle, cnt<=0.
  - If have_prev: period<=prev_half+m, period_valid<=1.
  - Then prev_half<=m, have_prev<=1.
- MEASURE, edge with m < MIN_HALF:
  - Edge ignored, cnt keeps counting, no pulses.
  - s3 still tracks s2, so the next opposite edge is seen as normal.
- MEASURE, no edge and m == TIMEOUT:
  - Go to TIMEOUT. timeout<=1, have_prev<=0.
  - half_period and period hold their last values.
- Simultaneous edge and m == TIMEOUT: the edge wins. It is a valid measurement of TIMEOUT cycles. Stay in MEASURE, timeout stays 0.
- TIMEOUT:
  - On edge: timeout<=0, cnt<=0, go to MEASURE. No valid pulse; the first edge only re-arms.
  - period needs two fresh halves before period_valid fires again.
- Valid pulses are registered, so they are high in the cycle after the accepting edge cycle together with the updated data. Never high two cycles in a row.
- Arithmetic: period = zero-extended prev_half + m in WIDTH+1 bits. No overflow is possible.
- Reset mid-measurement: immediate return to reset values. The first post-reset edge is treated as in IDLE.

Decomposition:
- Shared package clk_meas_pkg:
  - state enum {IDLE, MEASURE, TIMEOUT} (2 bits).
  - Default WIDTH, TIMEOUT and MIN_HALF constants, shared with the divider constants so benches can relate k and measured values.
- Sub-module sync_edge_det:
  - Contains the 2-flop synchroniser, delay flop and edge output.
  - Async active-high reset, all flops reset to 0.
  - Reusable for echo and button inputs.

Test Plan:
Bench settings for all scenarios: WIDTH=8, TIMEOUT=100, MIN_HALF=3.
- Symmetric wave: sig_in toggles every 5 clk. Expected:
  - After the 2nd edge: half_period=5, meas_valid pulse.
  - After the 3rd edge: period=10, period_valid pulse.
  - Steady state: one pulse per edge.
- Asymmetric wave: high 7, low 3. Expected:
  - half_period alternates 7/3.
  - period=10 on every edge after the 3rd.
- Glitch: in a 20-cycle wave, insert a 1-cycle pulse at cycle 10 (both edges 1 cycle apart, the first being 10 cycles after the previous edge). Expected:
  - The first edge of the pulse (m=10) is accepted.
  - The second edge (m=1 < 3) is rejected.
  - The next true edge reports m measured from the first glitch edge.
- Timeout: stop toggling. Expected:
  - timeout=1 exactly 100 cycles after the last edge; outputs hold.
  - Resume toggling every 5: the first edge clears timeout with no pulse, the 2nd gives half_period=5, the 3rd gives period=10.
- Boundary: place an edge exactly at m=100. Expected: meas_valid with half_period=100, timeout stays 0.
- Async reset: assert rst mid-count for half a clk period. Expected:
  - All outputs 0 immediately.
  - After release, the first edge gives no pulse.
- Divider check: drive sig_in from a divider with k=4. Expected: half_period=5 and period=10 constantly.
